// File: rtl/alu_response_monitor_if.sv
// Bus bundle between the ALU output side and the response monitor.
//
// Handshake: `sample` is a one-cycle strobe with no backpressure. The monitor
// accepts the current w/zer/neg on a rising clk edge when sample=1, the monitor
// is running and start=0; in every other case the strobe is simply ignored.
// start is a one-cycle command that (re)opens a run window.
interface alu_response_monitor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sample;
  logic [WIDTH-1:0] w;
  logic             zer;
  logic             neg;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] signature;
  logic [15:0]      sample_count;
  logic [15:0]      zero_count;
  logic [15:0]      neg_count;
  logic [15:0]      err_count;
  logic [15:0]      first_err_idx;
  logic [1:0]       dbg_state;

  modport master (
    output start, sample, w, zer, neg,
    input  busy, done, signature, sample_count, zero_count, neg_count,
           err_count, first_err_idx, dbg_state
  );

  modport slave (
    input  start, sample, w, zer, neg,
    output busy, done, signature, sample_count, zero_count, neg_count,
           err_count, first_err_idx, dbg_state
  );
endinterface

// File: rtl/alu_response_monitor.sv
// ALU response monitor: checks zer/neg flags against w for each strobed sample,
// compresses results into a MISR signature and keeps saturating tallies over a
// run window of N_SAMPLES accepted samples.
module alu_response_monitor #(
  parameter int               WIDTH     = 16,
  parameter logic [15:0]      N_SAMPLES = 16'd1000,
  parameter logic [WIDTH-1:0] POLY      = 16'h100B,
  parameter logic [WIDTH-1:0] SEED      = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_response_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_signature;
  logic [15:0]      r_sample_count;
  logic [15:0]      r_zero_count;
  logic [15:0]      r_neg_count;
  logic [15:0]      r_err_count;
  logic [15:0]      r_first_err_idx;

  logic             w_accept;
  logic             w_last;
  logic             w_err;
  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] w_misr_next;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  // start wins over a coincident strobe, so that sample is dropped.
  assign w_accept = bus.sample && (r_state == ST_RUN) && !bus.start;
  assign w_last   = w_accept && (r_sample_count == N_SAMPLES - 16'd1);

  // One error per sample, however many flags disagree with w.
  assign w_err = (bus.zer != (bus.w == '0)) || (bus.neg != bus.w[WIDTH-1]);

  // Flags folded into the two LSBs so a flag-only fault still moves the signature.
  assign w_data      = bus.w ^ {{(WIDTH-2){1'b0}}, bus.zer, bus.neg};
  assign w_misr_next = {r_signature[WIDTH-2:0], 1'b0}
                     ^ (r_signature[WIDTH-1] ? POLY : '0)
                     ^ w_data;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next_state = ST_RUN;
      ST_RUN: begin
        if (bus.start)   w_next_state = ST_RUN;
        else if (w_last) w_next_state = ST_DONE;
      end
      ST_DONE: if (bus.start) w_next_state = ST_RUN;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Signature and tallies: cleared on start, updated on each accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_signature     <= SEED;
      r_sample_count  <= 16'd0;
      r_zero_count    <= 16'd0;
      r_neg_count     <= 16'd0;
      r_err_count     <= 16'd0;
      r_first_err_idx <= 16'hFFFF;
    end else if (bus.start) begin
      r_signature     <= SEED;
      r_sample_count  <= 16'd0;
      r_zero_count    <= 16'd0;
      r_neg_count     <= 16'd0;
      r_err_count     <= 16'd0;
      r_first_err_idx <= 16'hFFFF;
    end else if (w_accept) begin
      r_signature    <= w_misr_next;
      r_sample_count <= sat_inc(r_sample_count, 1'b1);
      r_zero_count   <= sat_inc(r_zero_count, bus.zer);
      r_neg_count    <= sat_inc(r_neg_count, bus.neg);
      r_err_count    <= sat_inc(r_err_count, w_err);
      if (w_err && (r_first_err_idx == 16'hFFFF)) r_first_err_idx <= r_sample_count;
    end
  end

  assign bus.busy          = (r_state == ST_RUN);
  assign bus.done          = (r_state == ST_DONE);
  assign bus.signature     = r_signature;
  assign bus.sample_count  = r_sample_count;
  assign bus.zero_count    = r_zero_count;
  assign bus.neg_count     = r_neg_count;
  assign bus.err_count     = r_err_count;
  assign bus.first_err_idx = r_first_err_idx;
  assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_alu_response_monitor.sv
// Bench for alu_response_monitor: three instances with different window
// lengths share one stimulus set; `sel` routes stimulus and observation.
module tb_alu_response_monitor;

  logic clk;
  logic rst;

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  alu_response_monitor_if #(.WIDTH(16)) if2 ();
  alu_response_monitor_if #(.WIDTH(16)) if4 ();
  alu_response_monitor_if #(.WIDTH(16)) ifl ();

  alu_response_monitor #(.WIDTH(16), .N_SAMPLES(16'd2), .POLY(16'h100B), .SEED(16'h0000))
    u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  alu_response_monitor #(.WIDTH(16), .N_SAMPLES(16'd4), .POLY(16'h100B), .SEED(16'h0000))
    u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  alu_response_monitor #(.WIDTH(16), .N_SAMPLES(16'd10000), .POLY(16'h100B), .SEED(16'h0000))
    u_dutl (.clk(clk), .rst(rst), .bus(ifl.slave));

  int unsigned sel;
  logic        d_start, d_sample, d_zer, d_neg;
  logic [15:0] d_w;

  assign if2.start  = d_start  && (sel == 0);
  assign if2.sample = d_sample && (sel == 0);
  assign if4.start  = d_start  && (sel == 1);
  assign if4.sample = d_sample && (sel == 1);
  assign ifl.start  = d_start  && (sel == 2);
  assign ifl.sample = d_sample && (sel == 2);
  assign if2.w = d_w;  assign if2.zer = d_zer;  assign if2.neg = d_neg;
  assign if4.w = d_w;  assign if4.zer = d_zer;  assign if4.neg = d_neg;
  assign ifl.w = d_w;  assign ifl.zer = d_zer;  assign ifl.neg = d_neg;

  logic        o_busy, o_done;
  logic [15:0] o_sig, o_cnt, o_zc, o_nc, o_err, o_first;

  always_comb begin
    o_busy = if2.busy; o_done = if2.done; o_sig = if2.signature;
    o_cnt = if2.sample_count; o_zc = if2.zero_count; o_nc = if2.neg_count;
    o_err = if2.err_count; o_first = if2.first_err_idx;
    if (sel == 1) begin
      o_busy = if4.busy; o_done = if4.done; o_sig = if4.signature;
      o_cnt = if4.sample_count; o_zc = if4.zero_count; o_nc = if4.neg_count;
      o_err = if4.err_count; o_first = if4.first_err_idx;
    end else if (sel == 2) begin
      o_busy = ifl.busy; o_done = ifl.done; o_sig = ifl.signature;
      o_cnt = ifl.sample_count; o_zc = ifl.zero_count; o_nc = ifl.neg_count;
      o_err = ifl.err_count; o_first = ifl.first_err_idx;
    end
  end

  // Scoreboard counters.
  int n_vec;
  int n_fail;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic busy, input logic done,
                         input logic [15:0] sig, input logic [15:0] cnt,
                         input logic [15:0] zc, input logic [15:0] nc,
                         input logic [15:0] err, input logic [15:0] first);
    chk({tag, ".busy"},  {15'd0, o_busy}, {15'd0, busy});
    chk({tag, ".done"},  {15'd0, o_done}, {15'd0, done});
    chk({tag, ".sig"},   o_sig,   sig);
    chk({tag, ".cnt"},   o_cnt,   cnt);
    chk({tag, ".zc"},    o_zc,    zc);
    chk({tag, ".nc"},    o_nc,    nc);
    chk({tag, ".err"},   o_err,   err);
    chk({tag, ".first"}, o_first, first);
  endtask

  // Driver: present inputs for one cycle, then settle just after the edge.
  task automatic step(input logic st, input logic smp, input logic [15:0] w,
                      input logic z, input logic n);
    d_start = st; d_sample = smp; d_w = w; d_zer = z; d_neg = n;
    @(posedge clk);
    #1;
    d_start = 1'b0; d_sample = 1'b0;
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] w,
                                       input logic z, input logic n);
    logic [15:0] d;
    logic [15:0] fb;
    d  = w ^ {14'd0, z, n};
    fb = s[15] ? 16'h100B : 16'h0000;
    return {s[14:0], 1'b0} ^ fb ^ d;
  endfunction

  typedef struct {
    logic        start, sample;
    logic [15:0] w;
    logic        zer, neg;
    logic        busy, done;
    logic [15:0] sig, cnt, zc, nc, err, first;
  } vec_t;

  vec_t vecs[13];
  logic [15:0] exp_q[$];

  initial begin
    logic [15:0] m_sig, m_zc, m_nc, rw;
    int          acc;
    logic        smp;

    n_vec = 0; n_fail = 0;
    sel = 0; d_start = 0; d_sample = 0; d_w = 0; d_zer = 0; d_neg = 0;

    // Window of 4: flag checks, post-done hold, restart, start collision, double-flag error.
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF};
    vecs[1]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 16'd1, 16'd1, 16'd0, 16'd0, 16'hFFFF};
    vecs[2]  = '{1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h8005, 16'd2, 16'd1, 16'd1, 16'd0, 16'hFFFF};
    vecs[3]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1001, 16'd3, 16'd1, 16'd1, 16'd1, 16'd2};
    vecs[4]  = '{1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1, 16'h5FFC, 16'd4, 16'd1, 16'd2, 16'd2, 16'd2};
    vecs[5]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5FFC, 16'd4, 16'd1, 16'd2, 16'd2, 16'd2};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF};
    vecs[7]  = '{1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 16'd1, 16'd0, 16'd0, 16'd0, 16'hFFFF};
    vecs[8]  = '{1'b0, 1'b0, 16'hABCD, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0001, 16'd1, 16'd0, 16'd0, 16'd0, 16'hFFFF};
    vecs[9]  = '{1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 16'd2, 16'd0, 16'd0, 16'd0, 16'hFFFF};
    vecs[10] = '{1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0007, 16'd3, 16'd0, 16'd0, 16'd0, 16'hFFFF};
    vecs[11] = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF};
    vecs[12] = '{1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0002, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sel = 1;
    chk_all("reset", 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].start, vecs[i].sample, vecs[i].w, vecs[i].zer, vecs[i].neg);
      chk_all($sformatf("vec%0d", i), vecs[i].busy, vecs[i].done, vecs[i].sig,
              vecs[i].cnt, vecs[i].zc, vecs[i].nc, vecs[i].err, vecs[i].first);
    end

    // Window of 2: signature sequence, done after the 2nd sample, post-done hold, restart.
    sel = 0;
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk_all("sig.start", 1'b1, 1'b0, 16'h0000, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0003);
    step(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
    chk("sig.s1", o_sig, exp_q.pop_front());
    chk("sig.s1_done", {15'd0, o_done}, 16'd0);
    step(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
    chk("sig.s2", o_sig, exp_q.pop_front());
    chk_all("sig.end", 1'b0, 1'b1, 16'h0003, 16'd2, 16'd0, 16'd0, 16'd0, 16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk_all("postdone", 1'b0, 1'b1, 16'h0003, 16'd2, 16'd0, 16'd0, 16'd0, 16'hFFFF);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk_all("restart", 1'b1, 1'b0, 16'h0000, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF);

    // Long window: asynchronous reset with 5 samples in, then ignored strobes in IDLE.
    sel = 2;
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
    chk("rstmid.cnt_before", o_cnt, 16'd5);
    #2 rst = 1'b1;
    #1;
    chk_all("rstmid", 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0);
    chk_all("idle", 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF);

    // Long random run against the reference model.
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    m_sig = 16'h0000; m_zc = 0; m_nc = 0; acc = 0;
    for (int cyc = 0; cyc < 60000 && acc < 10000; cyc++) begin
      smp = 1'($urandom_range(0, 1));
      rw  = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 15) == 0) rw = 16'h0000;
      if (smp) begin
        m_sig = misr(m_sig, rw, rw == 16'h0000, rw[15]);
        m_zc  = m_zc + ((rw == 16'h0000) ? 16'd1 : 16'd0);
        m_nc  = m_nc + (rw[15] ? 16'd1 : 16'd0);
        acc++;
      end
      step(1'b0, smp, rw, rw == 16'h0000, rw[15]);
    end
    chk("long.accepted", 16'(acc), 16'd10000);
    chk_all("long", 1'b0, 1'b1, m_sig, 16'd10000, m_zc, m_nc, 16'd0, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
